// File: rtl/im2col_conv_unit8.sv
// 3x3 valid-mode convolution over a pixel strip held in an internal ROM.
// Each window is fetched, multiplied, summed, saturated and stored in a result RAM.
module im2col_conv_unit8 #(
    parameter int IMG_W     = 224,
    parameter int IMG_H     = 28,
    parameter int DATA_W    = 9,
    parameter     INIT_FILE = "horizontal_strip_8.mem"
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     kernel_read_complete,
    input  logic signed [DATA_W-1:0] kernel_0,
    input  logic signed [DATA_W-1:0] kernel_1,
    input  logic signed [DATA_W-1:0] kernel_2,
    input  logic signed [DATA_W-1:0] kernel_3,
    input  logic signed [DATA_W-1:0] kernel_4,
    input  logic signed [DATA_W-1:0] kernel_5,
    input  logic signed [DATA_W-1:0] kernel_6,
    input  logic signed [DATA_W-1:0] kernel_7,
    input  logic signed [DATA_W-1:0] kernel_8,
    input  logic [15:0]              strip8_addr,
    output logic                     done,
    output logic signed [DATA_W-1:0] out
);
    localparam int OW    = IMG_W - 2;
    localparam int OH    = IMG_H - 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWIN  = OW * OH;
    localparam int PA_W  = $clog2(NPIX);
    localparam int RA_W  = $clog2(NWIN);
    localparam int H_W   = $clog2(OW);
    localparam int P_W   = 2 * DATA_W;
    localparam int SUM_W = P_W + 4;
    localparam int MAXV  = 2 ** (DATA_W - 1) - 1;
    localparam int MINV  = -(2 ** (DATA_W - 1));

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_MULT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic signed [DATA_W-1:0] rom [NPIX];
    logic signed [DATA_W-1:0] ram [NWIN];

    logic [2:0]               state;
    logic [3:0]               k;
    logic [H_W-1:0]           h;
    logic [PA_W-1:0]          base;
    logic [RA_W-1:0]          widx;
    logic signed [DATA_W-1:0] kreg [9];
    logic signed [DATA_W-1:0] tap  [9];
    logic signed [P_W-1:0]    p    [9];
    logic [PA_W-1:0]          win_off;
    logic [PA_W-1:0]          rom_addr;
    logic                     rom_en;
    logic signed [DATA_W-1:0] rom_data;
    logic signed [SUM_W-1:0]  sum;
    logic signed [DATA_W-1:0] sat_val;
    logic                     last_win;

    assign done     = (state == S_DONE);
    assign rom_en   = (state == S_FETCH);
    assign rom_addr = base + win_off;
    assign last_win = (widx == RA_W'(NWIN - 1));

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        win_off = '0;
        case (k)
            4'd1:    win_off = PA_W'(1);
            4'd2:    win_off = PA_W'(2);
            4'd3:    win_off = PA_W'(IMG_W);
            4'd4:    win_off = PA_W'(IMG_W + 1);
            4'd5:    win_off = PA_W'(IMG_W + 2);
            4'd6:    win_off = PA_W'(2 * IMG_W);
            4'd7:    win_off = PA_W'(2 * IMG_W + 1);
            4'd8:    win_off = PA_W'(2 * IMG_W + 2);
            default: win_off = '0;
        endcase
    end

    // Nine products always fit in SUM_W bits, so the adder tree cannot overflow.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) sum = sum + SUM_W'(p[i]);
        if (sum > $signed(SUM_W'(MAXV)))
            sat_val = DATA_W'(MAXV);
        else if (sum < $signed(SUM_W'(MINV)))
            sat_val = DATA_W'(MINV);
        else
            sat_val = sum[DATA_W-1:0];
    end

    // NOTE: memories carry no reset; ROM data and RAM contents are plain storage, not control state.
    always_ff @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
        if (state == S_WRITE) ram[widx] <= sat_val;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= '0;
            h     <= '0;
            base  <= '0;
            widx  <= '0;
            out   <= '0;
            for (int i = 0; i < 9; i++) begin
                kreg[i] <= '0;
                tap[i]  <= '0;
                p[i]    <= '0;
            end
        end else begin
            out <= '0;
            case (state)
                S_IDLE: begin
                    if (start && kernel_read_complete) begin
                        kreg[0] <= kernel_0; kreg[1] <= kernel_1; kreg[2] <= kernel_2;
                        kreg[3] <= kernel_3; kreg[4] <= kernel_4; kreg[5] <= kernel_5;
                        kreg[6] <= kernel_6; kreg[7] <= kernel_7; kreg[8] <= kernel_8;
                        k     <= '0;
                        h     <= '0;
                        base  <= '0;
                        widx  <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // ROM data arriving now belongs to the address issued one cycle earlier.
                    if (k != 4'd0) tap[k - 4'd1] <= rom_data;
                    if (k == 4'd8) begin
                        k     <= '0;
                        state <= S_WAIT;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                S_WAIT: begin
                    tap[8] <= rom_data;
                    state  <= S_MULT;
                end
                S_MULT: begin
                    for (int i = 0; i < 9; i++) p[i] <= tap[i] * kreg[i];
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    widx <= widx + RA_W'(1);
                    // Row wrap skips the two right-edge columns that have no full window.
                    if (h == H_W'(OW - 1)) begin
                        h    <= '0;
                        base <= base + PA_W'(3);
                    end else begin
                        h    <= h + H_W'(1);
                        base <= base + PA_W'(1);
                    end
                    state <= last_win ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    if (strip8_addr < 16'(NWIN))
                        out <= ram[strip8_addr[RA_W-1:0]];
                    else
                        out <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_im2col_conv_unit8.sv
// Directed bench for im2col_conv_unit8 on a reduced 24x12 strip (22x10 windows).
module tb_im2col_conv_unit8;
    localparam int W   = 24;
    localparam int H   = 12;
    localparam int OW  = W - 2;
    localparam int OH  = H - 2;
    localparam int NP  = W * H;
    localparam int NW  = OW * OH;
    localparam int RUN = NW * 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              krc = 1'b0;
    logic signed [8:0] kin [9];
    logic [15:0]       raddr = '0;
    logic              done;
    logic signed [8:0] out;

    int checks = 0;
    int failures = 0;
    int img [NP];
    int kv [9];
    int gold [NW];

    im2col_conv_unit8 #(.IMG_W(W), .IMG_H(H), .DATA_W(9), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .start(start), .kernel_read_complete(krc),
        .kernel_0(kin[0]), .kernel_1(kin[1]), .kernel_2(kin[2]),
        .kernel_3(kin[3]), .kernel_4(kin[4]), .kernel_5(kin[5]),
        .kernel_6(kin[6]), .kernel_7(kin[7]), .kernel_8(kin[8]),
        .strip8_addr(raddr), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_image(input bit ramp, input int val);
        for (int a = 0; a < NP; a++) begin
            img[a] = ramp ? (a % 256) : val;
            dut.rom[a] = 9'(img[a]);
        end
    endtask

    task automatic set_kernel(input int k0, input int k1, input int k2, input int k3,
                              input int k4, input int k5, input int k6, input int k7, input int k8);
        kv[0] = k0; kv[1] = k1; kv[2] = k2; kv[3] = k3; kv[4] = k4;
        kv[5] = k5; kv[6] = k6; kv[7] = k7; kv[8] = k8;
        for (int i = 0; i < 9; i++) kin[i] = 9'(kv[i]);
    endtask

    task automatic compute_gold();
        for (int v = 0; v < OH; v++)
            for (int h = 0; h < OW; h++) begin
                int s;
                s = 0;
                for (int t = 0; t < 9; t++) s += img[(v + t / 3) * W + h + t % 3] * kv[t];
                gold[v * OW + h] = (s > 255) ? 255 : (s < -256) ? -256 : s;
            end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input bit scramble);
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        krc   = 1'b1;
        @(posedge clk);
        #1;
        if (scramble) for (int i = 0; i < 9; i++) kin[i] = 9'sd7;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < RUN + 50) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 100) check({tag, "_out_zero_midrun"}, out, 0);
        end
        check({tag, "_cycles"}, n, RUN);
        check({tag, "_done"}, done, 1);
        for (int i = 0; i < 9; i++) kin[i] = 9'(kv[i]);
    endtask

    task automatic read_one(input int addr, output logic signed [8:0] val);
        @(negedge clk);
        raddr = 16'(addr);
        @(posedge clk);
        @(negedge clk);
        val = out;
    endtask

    // Pipelined sweep: the value for address i-1 is visible while address i is driven.
    task automatic sweep(input string tag);
        for (int i = 0; i <= NW + 1; i++) begin
            @(negedge clk);
            if (i > 0 && i <= NW) check($sformatf("%s[%0d]", tag, i - 1), out, gold[i - 1]);
            if (i == NW + 1) check({tag, "_oob"}, out, 0);
            raddr = 16'(i);
        end
    endtask

    initial begin
        logic signed [8:0] v;
        int rom_hits;
        for (int i = 0; i < 9; i++) kin[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_done", done, 0);
        check("reset_out", out, 0);

        // Ramp image, identity kernel; kernel_read_complete held low first.
        load_image(1'b1, 0);
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        compute_gold();
        rom_hits = 0;
        @(negedge clk);
        start = 1'b1;
        krc   = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (dut.rom_en) rom_hits++;
        end
        check("no_krc_rom_idle", rom_hits, 0);
        check("no_krc_done", done, 0);
        run_to_done("identity", 1'b0);
        read_one(0, v);     check("identity_out0", v, 25);
        read_one(21, v);    check("identity_out21", v, 46);
        read_one(NW - 1, v); check("identity_last_wrap", v, 6);
        read_one(16'hFFFF, v); check("identity_oob_ffff", v, 0);
        sweep("identity");

        // All-ones kernel; kernel inputs scrambled after launch must be ignored.
        do_reset();
        set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
        compute_gold();
        run_to_done("ones", 1'b1);
        read_one(0, v);   check("ones_out0", v, 225);
        read_one(176, v); check("ones_sat_176", v, 255);
        sweep("ones");

        // Positive and negative saturation.
        do_reset();
        load_image(1'b0, 255);
        set_kernel(255, 255, 255, 255, 255, 255, 255, 255, 255);
        compute_gold();
        run_to_done("satpos", 1'b0);
        read_one(100, v); check("satpos_100", v, 255);
        sweep("satpos");

        do_reset();
        load_image(1'b0, -256);
        compute_gold();
        run_to_done("satneg", 1'b0);
        read_one(100, v); check("satneg_100", v, -256);
        sweep("satneg");

        // Reset mid-run, then rerun ramp/identity from window 0.
        do_reset();
        load_image(1'b1, 0);
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        compute_gold();
        @(negedge clk);
        start = 1'b1;
        krc   = 1'b1;
        repeat (1000) @(posedge clk);
        #2;
        reset = 1'b1;
        start = 1'b0;
        #1;
        check("midreset_done", done, 0);
        check("midreset_out", out, 0);
        @(negedge clk);
        reset = 1'b0;
        run_to_done("rerun", 1'b0);
        sweep("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
